// File: rtl/apb_requester_if.sv
// Command, response and APB bus signals of the APB requester, grouped as one bundle.
// The master modport is the requester's view; slave is the environment's view.
interface apb_requester_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);
  // Command channel
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  // Response channel
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  // APB bus
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic [DATA_W-1:0] prdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, pready, prdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, pready, prdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_requester.sv
// APB requester: accepts one command on a valid/ready channel, runs it as a single APB
// transfer (SETUP then ACCESS, honouring wait states) and returns the result on a
// valid/ready response channel. A timeout aborts transfers whose completer never answers.
module apb_requester #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input logic             pclk,
  input logic             prst_n,
  apb_requester_if.master bus
);

  // A zero-width counter is not legal, so TIMEOUT = 0 keeps a 1-bit (saturating) counter.
  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e            state_q;
  logic [CntW-1:0]   wait_cnt_q;
  logic              psel_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;
  logic              timeout_hit;

  // The current ACCESS cycle is the TIMEOUT-th one (counter starts at 0 in the first).
  assign timeout_hit = (TIMEOUT != 0) && (32'(wait_cnt_q) == TIMEOUT - 1);

  // Transfer FSM with all bus and response outputs registered.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state_q     <= StIdle;
      wait_cnt_q  <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.cmd_valid) begin
            pwrite_q  <= bus.cmd_write;
            paddr_q   <= bus.cmd_addr;
            pwdata_q  <= bus.cmd_wdata;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            state_q   <= StSetup;
          end
        end
        StSetup: begin
          penable_q  <= 1'b1;
          wait_cnt_q <= '0;
          state_q    <= StAccess;
        end
        StAccess: begin
          if (bus.pready) begin
            // Success wins even on the timeout cycle.
            rsp_rdata_q <= pwrite_q ? '0 : bus.prdata;
            rsp_err_q   <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
          end else if (timeout_hit) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
          end else if (wait_cnt_q != '1) begin
            wait_cnt_q <= wait_cnt_q + CntW'(1);
          end
        end
        StResp: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: begin
          psel_q      <= 1'b0;
          penable_q   <= 1'b0;
          rsp_valid_q <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign bus.cmd_ready = (state_q == StIdle);
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_requester.sv
// Directed testbench for apb_requester (TIMEOUT = 4).
module tb_apb_requester;

  logic pclk;
  logic prst_n;
  int   errors = 0;
  int   checks = 0;
  int   psel_cyc = 0;
  int   pen_cyc = 0;
  int   psel_base;
  int   pen_base;

  apb_requester_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  apb_requester #(
    .ADDR_W (5),
    .DATA_W (32),
    .TIMEOUT(4)
  ) dut (
    .pclk  (pclk),
    .prst_n(prst_n),
    .bus   (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Running count of rising edges that see psel / penable high.
  always @(posedge pclk) begin
    if (bus.psel) psel_cyc <= psel_cyc + 1;
    if (bus.penable) pen_cyc <= pen_cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic mark();
    psel_base = psel_cyc;
    pen_base  = pen_cyc;
  endtask

  task automatic issue(input logic wr, input logic [4:0] addr, input logic [31:0] wdata);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
  endtask

  task automatic handshake(input string tag);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk({tag, "_hs_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_hs_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
  endtask

  initial begin
    prst_n        = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.pready    = 1'b0;
    bus.prdata    = '0;
    #22;
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_psel", 32'(bus.psel), 32'd0);
    chk("rst_penable", 32'(bus.penable), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_paddr", 32'(bus.paddr), 32'd0);
    chk("rst_pwdata", bus.pwdata, 32'd0);
    prst_n = 1'b1;
    tick();

    // Write, zero wait states.
    mark();
    issue(1'b1, 5'd3, 32'hDEADBEEF);
    bus.pready = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    chk("w_setup_psel", 32'(bus.psel), 32'd1);
    chk("w_setup_penable", 32'(bus.penable), 32'd0);
    chk("w_setup_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("w_setup_pwrite", 32'(bus.pwrite), 32'd1);
    chk("w_setup_paddr", 32'(bus.paddr), 32'd3);
    chk("w_setup_pwdata", bus.pwdata, 32'hDEADBEEF);
    tick();
    chk("w_acc_penable", 32'(bus.penable), 32'd1);
    chk("w_acc_paddr", 32'(bus.paddr), 32'd3);
    chk("w_acc_pwdata", bus.pwdata, 32'hDEADBEEF);
    tick();
    chk("w_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("w_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("w_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("w_rsp_psel", 32'(bus.psel), 32'd0);
    chk("w_psel_cycles", 32'(psel_cyc - psel_base), 32'd2);
    chk("w_pen_cycles", 32'(pen_cyc - pen_base), 32'd1);
    handshake("w");

    // Read, one wait state.
    mark();
    issue(1'b0, 5'd3, 32'h0);
    bus.pready = 1'b0;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    chk("r1_wait_penable", 32'(bus.penable), 32'd1);
    chk("r1_wait_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    bus.pready = 1'b1;
    bus.prdata = 32'hDEADBEEF;
    tick();
    bus.pready = 1'b0;
    bus.prdata = 32'h0;
    chk("r1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("r1_rsp_rdata", bus.rsp_rdata, 32'hDEADBEEF);
    chk("r1_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("r1_psel_cycles", 32'(psel_cyc - psel_base), 32'd3);
    chk("r1_pen_cycles", 32'(pen_cyc - pen_base), 32'd2);
    handshake("r1");

    // Timeout: pready stuck low, expect abort after exactly 4 ACCESS cycles.
    mark();
    issue(1'b0, 5'd7, 32'h0);
    bus.prdata = 32'h12345678;
    tick();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("to_still_access", 32'(bus.penable), 32'd1);
    chk("to_no_rsp_yet", 32'(bus.rsp_valid), 32'd0);
    tick();
    chk("to_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("to_rsp_err", 32'(bus.rsp_err), 32'd1);
    chk("to_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("to_psel", 32'(bus.psel), 32'd0);
    chk("to_penable", 32'(bus.penable), 32'd0);
    chk("to_pen_cycles", 32'(pen_cyc - pen_base), 32'd4);
    handshake("to");

    // pready rises on the 4th ACCESS cycle: success wins.
    mark();
    issue(1'b0, 5'd12, 32'h0);
    bus.prdata = 32'hA5A50F0F;
    tick();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    bus.pready = 1'b1;
    tick();
    bus.pready = 1'b0;
    chk("late_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("late_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("late_rsp_rdata", bus.rsp_rdata, 32'hA5A50F0F);
    chk("late_pen_cycles", 32'(pen_cyc - pen_base), 32'd4);
    handshake("late");

    // Response back-pressure with the next command held valid.
    issue(1'b1, 5'd9, 32'h00001111);
    bus.pready = 1'b1;
    tick();
    issue(1'b0, 5'd31, 32'hFFFFFFFF);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_rsp_err", 32'(bus.rsp_err), 32'd0);
      chk("bp_rsp_rdata", bus.rsp_rdata, 32'd0);
      chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      chk("bp_psel", 32'(bus.psel), 32'd0);
      chk("bp_paddr_hold", 32'(bus.paddr), 32'd9);
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("bp_hs_valid", 32'(bus.rsp_valid), 32'd0);
    chk("bp_hs_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("bp_hs_psel", 32'(bus.psel), 32'd0);
    tick();
    bus.cmd_valid = 1'b0;
    chk("bp_next_psel", 32'(bus.psel), 32'd1);
    chk("bp_next_paddr", 32'(bus.paddr), 32'd31);
    chk("bp_next_pwrite", 32'(bus.pwrite), 32'd0);
    bus.prdata = 32'h0BADF00D;
    tick();
    tick();
    chk("bp_next_rdata", bus.rsp_rdata, 32'h0BADF00D);
    chk("bp_next_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    handshake("bp_next");

    // Reset asserted during ACCESS.
    issue(1'b0, 5'd2, 32'h0);
    bus.pready = 1'b0;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    chk("rm_in_access", 32'(bus.penable), 32'd1);
    #2;
    prst_n = 1'b0;
    #1;
    chk("rm_psel", 32'(bus.psel), 32'd0);
    chk("rm_penable", 32'(bus.penable), 32'd0);
    chk("rm_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    #3;
    prst_n = 1'b1;
    bus.pready = 1'b1;
    bus.rsp_ready = 1'b1;
    #1;
    chk("rm_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rm_no_rsp", 32'(bus.rsp_valid), 32'd0);
      chk("rm_no_psel", 32'(bus.psel), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
